// File: rtl/dtw_ref_arb_pkg.sv
// dtw_ref_arb_pkg: state encoding, default parameters and a one-hot decode helper for the reference-memory arbiter
package dtw_ref_arb_pkg;
    typedef enum logic [1:0] {
        NOREF = 2'd0,
        IDLE  = 2'd1,
        GRANT = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;
    localparam int DEF_NUM_REQ          = 4;
    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_REFMEM_PTR_WIDTH = 20;
    localparam int DEF_RD_LATENCY       = 3;
    localparam int DEF_MAX_BURST        = 16;
    function automatic int oh2idx(input logic [7:0] oh);
        oh2idx = 0;
        for (int k = 0; k < 8; k++)
            if (oh[k]) oh2idx = k;
    endfunction
endpackage

// File: rtl/dtw_ref_arbiter_if.sv
// dtw_ref_arbiter_if: requester-side bus of the reference-memory arbiter (requests, grants, tagged read data)
interface dtw_ref_arbiter_if
    import dtw_ref_arb_pkg::*;
#(
    parameter int NUM_REQ          = DEF_NUM_REQ,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int REFMEM_PTR_WIDTH = DEF_REFMEM_PTR_WIDTH
);
    logic [NUM_REQ-1:0]                  req_in;
    logic [NUM_REQ*REFMEM_PTR_WIDTH-1:0] req_addr_in;
    logic [NUM_REQ-1:0]                  gnt_out;
    logic [NUM_REQ-1:0]                  rvalid_out;
    logic [DATA_WIDTH-1:0]               rdata_out;
    modport master (output req_in, req_addr_in, input gnt_out, rvalid_out, rdata_out);
    modport slave  (input req_in, req_addr_in, output gnt_out, rvalid_out, rdata_out);
endinterface

// File: rtl/dtw_rr_pick.sv
// dtw_rr_pick: combinational round-robin pick, first requester at or after ptr_in with wrap-around
module dtw_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IW-1:0]      ptr_in,
    output logic [NUM_REQ-1:0] win_out,
    output logic               any_out
);
    logic [IW:0] w_s;
    // scan from farthest to nearest so the nearest requester is written last and wins
    always_comb begin
        win_out = '0;
        w_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_s = {1'b0, ptr_in} + (IW+1)'(k);
            w_s = (w_s >= (IW+1)'(NUM_REQ)) ? w_s - (IW+1)'(NUM_REQ) : w_s;
            if (req_in[w_s[IW-1:0]]) win_out = NUM_REQ'(1) << w_s[IW-1:0];
        end
    end
    assign any_out = |req_in;
endmodule

// File: rtl/dtw_ref_arbiter.sv
// dtw_ref_arbiter: round-robin, burst-capped sharing of one reference-memory read port among NUM_REQ requesters,
// with tagged fixed-latency returns, reference-valid gating and drain-before-reload.
module dtw_ref_arbiter
    import dtw_ref_arb_pkg::*;
#(
    parameter int NUM_REQ          = DEF_NUM_REQ,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int REFMEM_PTR_WIDTH = DEF_REFMEM_PTR_WIDTH,
    parameter int RD_LATENCY       = DEF_RD_LATENCY,
    parameter int MAX_BURST        = DEF_MAX_BURST
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    dtw_ref_arbiter_if.slave            bus,
    output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
    input  logic [DATA_WIDTH-1:0]       ref_data_in,
    input  logic                        ref_load_done_in,
    input  logic                        ref_reload_in,
    output logic                        ref_valid_out,
    output logic                        load_ok_out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    arb_state_t                  r_state, w_state_nx;
    logic [NUM_REQ-1:0]          r_gnt, w_gnt_nx, w_win;
    logic [IW-1:0]               r_ptr, w_ptr_nx, r_own, w_own_nx, w_own_inc, w_pick_ptr, w_win_idx;
    logic [CW-1:0]               r_cnt, w_cnt_nx, w_cnt_inc;
    logic                        r_valid, w_valid_nx, r_load_ok;
    logic                        w_any, w_acc, w_done, w_others, w_empty_nx;
    logic [REFMEM_PTR_WIDTH-1:0] r_addr;
    // stage 0 is loaded with ref_addr_out, so the head sits RD_LATENCY edges after acceptance
    logic [RD_LATENCY:0]         r_tv, w_tv_nx;
    logic [IW-1:0]               r_ti [RD_LATENCY+1];

    assign w_acc      = |(bus.req_in & r_gnt);
    assign w_own_inc  = (r_own == IW'(NUM_REQ - 1)) ? '0 : r_own + 1'b1;
    assign w_pick_ptr = (r_state == GRANT) ? w_own_inc : r_ptr;
    assign w_win_idx  = IW'(oh2idx(8'(w_win)));
    assign w_cnt_inc  = r_cnt + CW'(w_acc);
    assign w_done     = w_cnt_inc == CW'(MAX_BURST);
    assign w_others   = |(bus.req_in & ~r_gnt);
    assign w_tv_nx    = {r_tv[RD_LATENCY-1:0], w_acc};
    assign w_empty_nx = ~|w_tv_nx;

    dtw_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_in  (bus.req_in),
        .ptr_in  (w_pick_ptr),
        .win_out (w_win),
        .any_out (w_any)
    );

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_ptr_nx   = r_ptr;
        w_own_nx   = r_own;
        w_cnt_nx   = r_cnt;
        w_valid_nx = r_valid;
        case (r_state)
            NOREF: begin
                if (ref_load_done_in) begin
                    w_state_nx = IDLE;
                    w_valid_nx = 1'b1;
                end
            end
            IDLE, GRANT: begin
                if (ref_reload_in) begin
                    w_state_nx = DRAIN;
                    w_gnt_nx   = '0;
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = '0;
                end else if (r_state == IDLE) begin
                    if (w_any) begin
                        w_state_nx = GRANT;
                        w_gnt_nx   = w_win;
                        w_own_nx   = w_win_idx;
                    end
                end else if (!bus.req_in[r_own] || (w_done && w_others)) begin
                    // hand over with no bubble; the pick already starts at owner+1
                    w_state_nx = w_any ? GRANT : IDLE;
                    w_gnt_nx   = w_win;
                    w_own_nx   = w_win_idx;
                    w_ptr_nx   = w_own_inc;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = w_done ? '0 : w_cnt_inc;
                end
            end
            DRAIN: begin
                if (w_empty_nx) w_state_nx = NOREF;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= NOREF;
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_own     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_load_ok <= 1'b0;
            r_addr    <= '0;
            r_tv      <= '0;
            r_ti      <= '{default: '0};
        end else begin
            r_state   <= w_state_nx;
            r_gnt     <= w_gnt_nx;
            r_ptr     <= w_ptr_nx;
            r_own     <= w_own_nx;
            r_cnt     <= w_cnt_nx;
            r_valid   <= w_valid_nx;
            r_load_ok <= (w_state_nx == NOREF) && w_empty_nx;
            if (w_acc) r_addr <= bus.req_addr_in[r_own*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];
            r_tv      <= w_tv_nx;
            r_ti[0]   <= r_own;
            for (int k = 1; k <= RD_LATENCY; k++) r_ti[k] <= r_ti[k-1];
        end
    end

    assign bus.gnt_out    = r_gnt;
    assign bus.rvalid_out = r_tv[RD_LATENCY] ? NUM_REQ'(1) << r_ti[RD_LATENCY] : '0;
    assign bus.rdata_out  = r_tv[RD_LATENCY] ? ref_data_in : '0;
    assign ref_addr_out   = r_addr;
    assign ref_valid_out  = r_valid;
    assign load_ok_out    = r_load_ok;
endmodule

// File: tb/tb_dtw_ref_arbiter.sv
// tb_dtw_ref_arbiter: scenario tasks plus a tagged read-return scoreboard for dtw_ref_arbiter
module tb_dtw_ref_arbiter;
    import dtw_ref_arb_pkg::*;
    localparam int N = 4, DW = 16, AW = 20, L = 3, MB = 4;
    typedef struct packed {
        logic [2:0]    idx;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic [AW-1:0] ref_addr_out;
    logic [DW-1:0] ref_data_in;
    logic          ref_load_done_in = 1'b0;
    logic          ref_reload_in = 1'b0;
    logic          ref_valid_out, load_ok_out;
    logic [AW-1:0] addr [N];
    logic [AW-1:0] mp [L];
    exp_t          sb[$];
    exp_t          e;
    int            checks = 0, errors = 0, cyc = 0, nrv = 0;

    dtw_ref_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(AW)) bus();

    dtw_ref_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(AW), .RD_LATENCY(L), .MAX_BURST(MB)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .bus              (bus),
        .ref_addr_out     (ref_addr_out),
        .ref_data_in      (ref_data_in),
        .ref_load_done_in (ref_load_done_in),
        .ref_reload_in    (ref_reload_in),
        .ref_valid_out    (ref_valid_out),
        .load_ok_out      (load_ok_out)
    );

    always #5 clk_in = ~clk_in;
    assign bus.req_addr_in = {addr[3], addr[2], addr[1], addr[0]};
    // memory model: data for an address registered at edge E appears L edges later as addr+100
    assign ref_data_in = DW'(mp[L-1] + AW'(100));

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        mp[0] <= ref_addr_out;
        for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
    end

    always @(negedge clk_in) begin
        if (!rst_n_in) sb.delete();
        else begin
            if (bus.rvalid_out != '0) begin
                nrv++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected got rvalid=%b data=%h at cycle %0d", bus.rvalid_out, bus.rdata_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.rvalid_out !== N'(1) << e.idx || bus.rdata_out !== e.data || 32'(cyc) !== e.cyc) begin
                        errors++;
                        $display("FAIL rvalid_return got rvalid=%b data=%h cycle=%0d want rvalid=%b data=%h cycle=%0d",
                                 bus.rvalid_out, bus.rdata_out, cyc, N'(1) << e.idx, e.data, e.cyc);
                    end
                end
            end
            for (int i = 0; i < N; i++)
                if (bus.req_in[i] && bus.gnt_out[i])
                    sb.push_back('{idx: 3'(i), data: DW'(addr[i] + AW'(100)), cyc: 32'(cyc + 1 + L)});
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_gnt(input int i);
        bit got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            got = bus.gnt_out[i];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_gnt%0d got gnt=%b want bit %0d set within 20 cycles", i, bus.gnt_out, i);
        end
    endtask

    task automatic test_reset();
        bus.req_in = '0;
        for (int i = 0; i < N; i++) addr[i] = '0;
        #3 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({bus.gnt_out, bus.rvalid_out, ref_valid_out, load_ok_out} !== '0 || ref_addr_out !== '0 || bus.rdata_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rvalid=%b valid=%b load_ok=%b addr=%h want all 0",
                     bus.gnt_out, bus.rvalid_out, ref_valid_out, load_ok_out, ref_addr_out);
        end
        tick();
        tick();
        rst_n_in = 1'b1;
        bus.req_in = 4'b0001;
        tick();
        checks++;
        if (load_ok_out !== 1'b1 || bus.gnt_out !== '0) begin
            errors++;
            $display("FAIL noref_idle got load_ok=%b gnt=%b want 1 0000", load_ok_out, bus.gnt_out);
        end
        repeat (3) tick();
        checks++;
        if (bus.gnt_out !== '0) begin
            errors++;
            $display("FAIL noref_no_grant got gnt=%b want 0000", bus.gnt_out);
        end
        ref_load_done_in = 1'b1;
        tick();
        ref_load_done_in = 1'b0;
        checks++;
        if (bus.gnt_out !== '0 || ref_valid_out !== 1'b1 || load_ok_out !== 1'b0) begin
            errors++;
            $display("FAIL load_done got gnt=%b valid=%b load_ok=%b want 0000 1 0", bus.gnt_out, ref_valid_out, load_ok_out);
        end
        tick();
        checks++;
        if (bus.gnt_out !== 4'b0001) begin
            errors++;
            $display("FAIL first_grant got gnt=%b want 0001", bus.gnt_out);
        end
        bus.req_in = '0;
        tick();
        tick();
        checks++;
        if (bus.gnt_out !== '0) begin
            errors++;
            $display("FAIL release_idle got gnt=%b want 0000", bus.gnt_out);
        end
    endtask

    task automatic test_single();
        int n0 = nrv;
        addr[0] = AW'(5);
        bus.req_in = 4'b0001;
        wait_gnt(0);
        tick();
        addr[0] = AW'(6);
        tick();
        addr[0] = AW'(7);
        tick();
        bus.req_in = '0;
        repeat (L + 3) tick();
        checks++;
        if (nrv - n0 !== 3 || sb.size() !== 0) begin
            errors++;
            $display("FAIL single_returns got %0d returns %0d pending want 3 0", nrv - n0, sb.size());
        end
    endtask

    task automatic test_burst();
        logic [N-1:0] want;
        addr[0] = AW'('h10);
        addr[2] = AW'('h20);
        bus.req_in = 4'b0101;
        for (int k = 0; k < 16; k++) begin
            tick();
            want = ((k / MB) % 2 == 0) ? 4'b0100 : 4'b0001;
            checks++;
            if (bus.gnt_out !== want) begin
                errors++;
                $display("FAIL burst_grant k=%0d got gnt=%b want %b", k, bus.gnt_out, want);
            end
        end
        bus.req_in = '0;
        repeat (L + 4) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL burst_drain got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_rr_order();
        int got [4] = '{-1, -1, -1, -1};
        int want [4] = '{3, 0, 1, 2};
        int n = 0;
        logic [N-1:0] w;
        bus.req_in = 4'b0100;
        wait_gnt(2);
        tick();
        bus.req_in = '0;
        tick();
        tick();
        for (int i = 0; i < N; i++) addr[i] = AW'(i * 16 + 1);
        bus.req_in = 4'b1111;
        for (int t = 0; t < 40 && n < 4; t++) begin
            tick();
            w = bus.gnt_out & bus.req_in;
            for (int i = 0; i < N; i++)
                if (w[i]) begin
                    got[n] = i;
                    n++;
                    tick();
                    bus.req_in[i] = 1'b0;
                end
        end
        bus.req_in = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL rr_order slot=%0d got %0d want %0d", i, got[i], want[i]);
            end
        end
        repeat (L + 4) tick();
    endtask

    task automatic test_reload();
        int n0;
        bit ok_seen = 0;
        addr[0] = AW'('h40);
        bus.req_in = 4'b0001;
        wait_gnt(0);
        n0 = nrv;
        tick();
        tick();
        ref_reload_in = 1'b1;
        tick();
        ref_reload_in = 1'b0;
        checks++;
        if (bus.gnt_out !== '0 || ref_valid_out !== 1'b0 || load_ok_out !== 1'b0) begin
            errors++;
            $display("FAIL reload_edge got gnt=%b valid=%b load_ok=%b want 0000 0 0", bus.gnt_out, ref_valid_out, load_ok_out);
        end
        for (int t = 0; t < 12 && !ok_seen; t++) begin
            tick();
            ok_seen = load_ok_out;
        end
        bus.req_in = '0;
        checks++;
        if (!ok_seen || sb.size() !== 0 || nrv - n0 !== 3) begin
            errors++;
            $display("FAIL reload_drain got load_ok=%b pending=%0d returns=%0d want 1 0 3", ok_seen, sb.size(), nrv - n0);
        end
    endtask

    task automatic test_async_reset();
        int n0;
        ref_load_done_in = 1'b1;
        tick();
        ref_load_done_in = 1'b0;
        addr[0] = AW'('h50);
        bus.req_in = 4'b0001;
        wait_gnt(0);
        tick();
        tick();
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({bus.gnt_out, bus.rvalid_out, ref_valid_out, load_ok_out} !== '0 || ref_addr_out !== '0 || bus.rdata_out !== '0) begin
            errors++;
            $display("FAIL async_reset got gnt=%b rvalid=%b valid=%b load_ok=%b addr=%h want all 0",
                     bus.gnt_out, bus.rvalid_out, ref_valid_out, load_ok_out, ref_addr_out);
        end
        tick();
        tick();
        rst_n_in = 1'b1;
        n0 = nrv;
        repeat (L + 5) tick();
        checks++;
        if (nrv !== n0 || bus.gnt_out !== '0 || ref_valid_out !== 1'b0 || load_ok_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got returns=%0d gnt=%b valid=%b load_ok=%b want 0 0000 0 1",
                     nrv - n0, bus.gnt_out, ref_valid_out, load_ok_out);
        end
        bus.req_in = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_rr_order();
        test_reload();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
